// File: rtl/smi_mem_fuzz_write_data_gen_pkg.sv
// ============================================================================
// Module  : smi_mem_fuzz_write_data_gen_pkg
// Brief   : Shared types, constants and byte-mask helper for the fuzz
//           write-data generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package smi_mem_fuzz_write_data_gen_pkg;

    localparam int DATA_WIDTH_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // A single-word burst is both first and last, so both trims apply.
    function automatic logic [7:0] fn_byte_mask(
        input logic [2:0] offset,
        input logic [2:0] last_bytes,
        input logic       first,
        input logic       last
    );
        logic [7:0] m;
        m = 8'hFF;
        if (first) m = m & (8'hFF << offset);
        if (last)  m = m & (8'hFF >> (3'd7 - last_bytes));
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/smi_mem_fuzz_data_out_reg.sv
// ============================================================================
// Module  : smi_mem_fuzz_data_out_reg
// Brief   : One-entry valid/stop output register for word, mask and end flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module smi_mem_fuzz_data_out_reg (
    input  logic        clk,
    input  logic        srst,
    input  logic        i_load_valid,
    input  logic [63:0] i_word,
    input  logic [7:0]  i_mask,
    input  logic        i_end,
    output logic        o_ready,
    input  logic        i_stop,
    output logic        o_valid,
    output logic [63:0] o_word,
    output logic [7:0]  o_mask,
    output logic        o_end
);

    logic        r_valid;
    logic [63:0] r_word;
    logic [7:0]  r_mask;
    logic        r_end;

    // Accept a new word when empty or when the held word leaves this cycle.
    assign o_ready = ~r_valid | ~i_stop;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_valid <= 1'b0;
            r_word  <= 64'd0;
            r_mask  <= 8'd0;
            r_end   <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_load_valid;
            if (i_load_valid) begin
                r_word <= i_word;
                r_mask <= i_mask;
                r_end  <= i_end;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;
    assign o_mask  = r_mask;
    assign o_end   = r_end;

endmodule

`default_nettype wire

// File: rtl/smi_mem_fuzz_write_data_gen.sv
// ============================================================================
// Module  : smi_mem_fuzz_write_data_gen
// Brief   : Generates a masked, incrementing write-data burst per parameter set.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module smi_mem_fuzz_write_data_gen
    import smi_mem_fuzz_write_data_gen_pkg::*;
#(
    parameter int DataWidthBytes = DATA_WIDTH_BYTES
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          paramsValid,
    input  logic [63:0]                   paramBaseAddr,
    input  logic [31:0]                   paramByteLength,
    input  logic [63:0]                   paramDataInit,
    input  logic [63:0]                   paramDataIncr,
    output logic                          paramsStop,
    output logic                          dataValid,
    output logic [DataWidthBytes*8-1:0]   dataWord,
    output logic [DataWidthBytes-1:0]     dataMask,
    output logic                          dataEnd,
    input  logic                          dataStop,
    output logic [31:0]                   burstCount
);

    state_t      r_state;
    state_t      w_next_state;

    // Only the sub-word byte offset of the base address shapes the data.
    logic [2:0]  r_off;
    logic [31:0] r_len;
    logic [63:0] r_init;
    logic [63:0] r_incr;

    logic [31:0] r_word_count;
    logic [2:0]  r_last_bytes;
    logic [63:0] r_acc;
    logic [31:0] r_idx;
    logic        r_all_issued;
    logic [31:0] r_burst_count;

    logic [32:0] w_wc33;
    logic [31:0] w_word_count;
    logic [2:0]  w_last_bytes;
    logic        w_accept;
    logic        w_out_ready;
    logic        w_push;
    logic        w_is_last;
    logic [7:0]  w_mask;
    logic        w_end_xfer;

    assign w_accept     = (r_state == ST_IDLE) & paramsValid;
    assign w_wc33       = {30'd0, r_off} + {1'b0, r_len} + 33'd7;
    assign w_word_count = 32'(w_wc33 >> 3);
    assign w_last_bytes = r_off + r_len[2:0] - 3'd1;

    assign w_is_last  = (r_idx == r_word_count - 32'd1);
    assign w_push     = (r_state == ST_STREAM) & ~r_all_issued & w_out_ready;
    assign w_mask     = fn_byte_mask(r_off, r_last_bytes, (r_idx == 32'd0), w_is_last);
    assign w_end_xfer = (r_state == ST_STREAM) & dataValid & dataEnd & ~dataStop;

    always_ff @(posedge clk) begin
        if (srst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        paramsStop   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                paramsStop = 1'b0;
                if (paramsValid) w_next_state = ST_SETUP;
            end
            ST_SETUP: begin
                if (r_len == 32'd0) w_next_state = ST_IDLE;
                else                w_next_state = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_end_xfer) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_off  <= paramBaseAddr[2:0];
            r_len  <= paramByteLength;
            r_init <= paramDataInit;
            r_incr <= paramDataIncr;
        end
        if (r_state == ST_SETUP) begin
            r_acc        <= r_init;
            r_word_count <= w_word_count;
            r_last_bytes <= w_last_bytes;
        end else if (w_push) begin
            r_acc <= r_acc + r_incr;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_idx         <= 32'd0;
            r_all_issued  <= 1'b0;
            r_burst_count <= 32'd0;
        end else begin
            if (r_state == ST_SETUP) begin
                r_idx        <= 32'd0;
                r_all_issued <= 1'b0;
                if (r_len == 32'd0) r_burst_count <= r_burst_count + 32'd1;
            end else if (w_push) begin
                r_idx <= r_idx + 32'd1;
                if (w_is_last) r_all_issued <= 1'b1;
            end
            if (w_end_xfer) r_burst_count <= r_burst_count + 32'd1;
        end
    end

    assign burstCount = r_burst_count;

    smi_mem_fuzz_data_out_reg u_out_reg (
        .clk          (clk),
        .srst         (srst),
        .i_load_valid (w_push),
        .i_word       (r_acc),
        .i_mask       (w_mask),
        .i_end        (w_is_last),
        .o_ready      (w_out_ready),
        .i_stop       (dataStop),
        .o_valid      (dataValid),
        .o_word       (dataWord),
        .o_mask       (dataMask),
        .o_end        (dataEnd)
    );

endmodule

`default_nettype wire

// File: tb/tb_smi_mem_fuzz_write_data_gen.sv
// ============================================================================
// Module  : tb_smi_mem_fuzz_write_data_gen
// Brief   : Directed scoreboard bench for the fuzz write-data generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_smi_mem_fuzz_write_data_gen;

    typedef struct packed {
        logic [63:0] word;
        logic [7:0]  mask;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        paramsValid = 1'b0;
    logic [63:0] paramBaseAddr = 64'd0;
    logic [31:0] paramByteLength = 32'd0;
    logic [63:0] paramDataInit = 64'd0;
    logic [63:0] paramDataIncr = 64'd0;
    logic        paramsStop;
    logic        dataValid;
    logic [63:0] dataWord;
    logic [7:0]  dataMask;
    logic        dataEnd;
    logic        dataStop = 1'b0;
    logic [31:0] burstCount;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    always #5 clk = ~clk;

    smi_mem_fuzz_write_data_gen #(.DataWidthBytes(8)) dut (
        .clk             (clk),
        .srst            (srst),
        .paramsValid     (paramsValid),
        .paramBaseAddr   (paramBaseAddr),
        .paramByteLength (paramByteLength),
        .paramDataInit   (paramDataInit),
        .paramDataIncr   (paramDataIncr),
        .paramsStop      (paramsStop),
        .dataValid       (dataValid),
        .dataWord        (dataWord),
        .dataMask        (dataMask),
        .dataEnd         (dataEnd),
        .dataStop        (dataStop),
        .burstCount      (burstCount)
    );

    // Output monitor: every transferred word must match the queue head.
    always @(negedge clk) begin
        if (!srst && dataValid && !dataStop) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_word got %h expected none", dataWord);
            end
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                pops++;
                checks++;
                assert ({dataWord, dataMask, dataEnd} === {e.word, e.mask, e.last}) else begin
                    errors++;
                    $error("FAIL word got %h/%h/%b expected %h/%h/%b",
                           dataWord, dataMask, dataEnd, e.word, e.mask, e.last);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_word(input logic [63:0] w, input logic [7:0] m, input logic l);
        exp_t e;
        e.word = w; e.mask = m; e.last = l;
        q.push_back(e);
    endtask

    // Returns at 1 time unit after the accepting clock edge.
    task automatic accept(input logic [63:0] addr, input logic [31:0] len,
                          input logic [63:0] init, input logic [63:0] incr);
        int n;
        @(negedge clk);
        paramsValid = 1'b1;
        paramBaseAddr = addr; paramByteLength = len;
        paramDataInit = init; paramDataIncr = incr;
        n = 0;
        while (paramsStop && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (paramsStop) begin
            checks++; errors++;
            $display("FAIL accept_timeout got paramsStop=1 expected 0");
        end
        @(posedge clk); #1;
        paramsValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || dataValid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] bc;
        int n;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;

        // Reset state
        chk("rst_valid", 64'(dataValid), 64'd0);
        chk("rst_word",  dataWord, 64'd0);
        chk("rst_mask",  64'(dataMask), 64'd0);
        chk("rst_end",   64'(dataEnd), 64'd0);
        chk("rst_count", 64'(burstCount), 64'd0);
        chk("rst_pstop", 64'(paramsStop), 64'd0);

        // Aligned two-word burst with latency check
        expect_word(64'h10, 8'hFF, 1'b0);
        expect_word(64'h11, 8'hFF, 1'b1);
        accept(64'h1000, 32'd16, 64'h10, 64'd1);
        chk("lat_c0", 64'(dataValid), 64'd0);
        @(posedge clk); #1;
        chk("lat_c1", 64'(dataValid), 64'd0);
        @(posedge clk); #1;
        chk("lat_c2", 64'(dataValid), 64'd1);
        chk("cnt_before", 64'(burstCount), 64'd0);
        drain();
        chk("cnt_after", 64'(burstCount), 64'd1);

        // Unaligned start spanning two words
        expect_word(64'h20, 8'hF8, 1'b0);
        expect_word(64'h21, 8'h07, 1'b1);
        accept(64'h1003, 32'd8, 64'h20, 64'd1);
        drain();

        // Single word with both edges trimmed
        expect_word(64'hAA, 8'h1C, 1'b1);
        accept(64'h2, 32'd3, 64'hAA, 64'd5);
        drain();
        chk("cnt_3", 64'(burstCount), 64'd3);

        // Wrapping data with dataStop toggling every cycle
        expect_word(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        expect_word(64'h1, 8'hFF, 1'b0);
        expect_word(64'h3, 8'hFF, 1'b1);
        accept(64'h0, 32'd24, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        n = 0;
        while (q.size() > 0 && n < 60) begin
            chk("pstop_busy", 64'(paramsStop), 64'd1);
            @(posedge clk); #1;
            dataStop = ~dataStop;
            n++;
        end
        dataStop = 1'b0;
        chk("toggle_left", 64'(q.size()), 64'd0);
        chk("pstop_idle", 64'(paramsStop), 64'd0);
        @(posedge clk); #1;
        chk("cnt_4", 64'(burstCount), 64'd4);

        // Zero-length burst: no words, count advances
        bc = burstCount;
        accept(64'h40, 32'd0, 64'h99, 64'd1);
        repeat (3) begin
            chk("zero_valid", 64'(dataValid), 64'd0);
            @(posedge clk); #1;
        end
        chk("zero_count", 64'(burstCount), 64'(bc + 32'd1));

        // Reset mid-burst after two words
        expect_word(64'h100, 8'hFF, 1'b0);
        expect_word(64'h110, 8'hFF, 1'b0);
        pops = 0;
        accept(64'h0, 32'd64, 64'h100, 64'h10);
        n = 0;
        while (pops < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_pops", 64'(pops), 64'd2);
        srst = 1'b1;
        dataStop = 1'b1;
        @(posedge clk); #1;
        chk("mid_valid", 64'(dataValid), 64'd0);
        chk("mid_count", 64'(burstCount), 64'd0);
        srst = 1'b0;
        dataStop = 1'b0;

        expect_word(64'h55, 8'hFF, 1'b1);
        accept(64'h0, 32'd8, 64'h55, 64'd1);
        drain();
        chk("post_count", 64'(burstCount), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
